// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue.
// Streams sequential instruction words from a single-outstanding-read memory
// port into a small circular FIFO of {pc, word} entries. The core sees the
// head entry and pops it with advance. A redirect flushes the queue and
// restarts fetch at a new PC. A read that is still in flight at redirect time
// is allowed to complete, and its data is dropped.
//
// state   | meaning
// --------+------------------------------------------------------------------
// FETCH   | normal operation; a request is presented whenever an entry is free
// DISCARD | a stale read (issued before a redirect) is outstanding; drop it
// FULL    | every entry is occupied and nothing is outstanding; no request

module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                req_addr,
    input  logic                       redirect,
    input  logic                       advance,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_ready,
    input  logic [31:0]                mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [31:0]        fetch_addr, fetch_addr_nx;
    logic [31:0]        stale_addr, stale_addr_nx;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count, count_nx;
    logic [31:0]        addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];

    logic               fire;
    logic               push;
    logic               pop;

    // Only the word address of a redirect target is used.
    logic               unused_req_lsb;
    assign unused_req_lsb = &{1'b0, req_addr[1:0]};

    // A request is presented in FETCH while there is room. Because the queue
    // cannot grow until the read completes, the request stays up and the
    // address stays put until mem_ready. In DISCARD, the stale request is
    // held on its original address until it completes.
    assign mem_req  = ~rst & (((state == ST_FETCH) & (count < DEPTH_C)) |
                              (state == ST_DISCARD));
    assign mem_addr = (state == ST_DISCARD) ? stale_addr : fetch_addr;

    assign fire = mem_req & mem_ready;
    // Data returned in DISCARD, or in the same cycle as a redirect, is dropped.
    assign push = fire & (state == ST_FETCH) & ~redirect;
    // Redirect wins over advance; advance on an empty queue is ignored.
    assign pop  = advance & inst_valid & ~redirect;

    // Head-entry outputs are driven from registered storage only. They are
    // forced to zero when the queue is empty, so reset shows zeros.
    assign inst_valid  = (count != '0);
    assign queue_count = count;
    assign inst        = inst_valid ? data_q[head] : 32'h0;
    assign inst_pc     = inst_valid ? addr_q[head] : 32'h0;

    // Next-state, fetch-address and occupancy decode.
    always_comb begin
        state_nx      = state;
        fetch_addr_nx = fetch_addr;
        stale_addr_nx = stale_addr;
        count_nx      = count;

        if (push && !pop) begin
            count_nx = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nx = count - CNT_W'(1);
        end

        if (redirect) begin
            count_nx      = '0;
            fetch_addr_nx = {req_addr[31:2], 2'b00};
            if (mem_req && !mem_ready) begin
                // The current read cannot be cancelled. Remember its address
                // so the request stays stable until it completes.
                state_nx      = ST_DISCARD;
                stale_addr_nx = mem_addr;
            end else begin
                state_nx = ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (push) begin
                        fetch_addr_nx = fetch_addr + 32'd4;
                    end
                    if (count_nx == DEPTH_C) begin
                        state_nx = ST_FULL;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ready) begin
                        state_nx = ST_FETCH;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_nx = ST_FETCH;
                    end
                end
                default: begin
                    state_nx = ST_FETCH;
                end
            endcase
        end
    end

    // Control state register; reset abandons any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            fetch_addr <= RESET_PC;
            stale_addr <= RESET_PC;
            count      <= '0;
        end else begin
            state      <= state_nx;
            fetch_addr <= fetch_addr_nx;
            stale_addr <= stale_addr_nx;
            count      <= count_nx;
        end
    end

    // Circular pointers; a redirect empties the queue by rewinding both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (redirect) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    // Entry storage. It needs no reset because occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= fetch_addr;
            data_q[tail] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue (DEPTH=4, RESET_PC=0).
// The memory responds with mem[a] = a + 32'hA000 after a configurable latency.
// A queue-based reference model predicts head contents, occupancy and the
// request stream every cycle.

module tb_inst_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   req_addr;
    logic          redirect;
    logic          advance;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_valid;
    logic [CW-1:0] queue_count;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr    (req_addr),
        .redirect    (redirect),
        .advance     (advance),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .queue_count (queue_count),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    // reference model: queue contents plus the fetch pointer and in-flight read
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_next;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_stale;

    // memory environment
    int          lat;
    int          cnt;
    bit          rand_lat;
    bit          env_fire;

    logic [31:0] issued[$];
    logic [31:0] popped[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_next     = RESET_PC;
        m_out_addr = RESET_PC;
        m_out      = 1'b0;
        m_stale    = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit r, input bit rd, input logic [31:0] ra, input bit adv);
        bit          e_req;
        logic [31:0] e_addr;
        rst      = r;
        redirect = rd;
        req_addr = ra;
        advance  = adv;
        if (r) model_reset();
        #1;
        e_req  = !r && (m_out || q.size() < DEPTH);
        e_addr = m_out ? m_out_addr : m_next;
        if (r || !mem_req) cnt = 0;
        else cnt++;
        mem_ready = mem_req && (cnt >= lat);
        mem_rdata = mem_ready ? mem_addr + 32'hA000 : $urandom;
        env_fire  = mem_req && mem_ready;
        #1;
        chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        chk("queue_count", 32'(queue_count), 32'(q.size()));
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0].a);
            chk("inst", inst, q[0].d);
        end else if (r) begin
            chk("rst_inst", inst, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
        end
        chk("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req) chk("mem_addr", mem_addr, e_addr);
        if (adv && inst_valid && !rd && !r) popped.push_back(inst_pc);
        if (env_fire) issued.push_back(mem_addr);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (rd) begin
            q.delete();
            m_out      = e_req && !mem_ready;
            m_stale    = m_out;
            m_out_addr = e_addr;
            m_next     = {ra[31:2], 2'b00};
        end else begin
            if (adv && q.size() != 0) void'(q.pop_front());
            if (e_req && mem_ready) begin
                if (!m_stale) begin
                    q.push_back('{a: e_addr, d: e_addr + 32'hA000});
                    m_next = e_addr + 32'd4;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (e_req) begin
                m_out      = 1'b1;
                m_out_addr = e_addr;
            end
        end
        if (env_fire) begin
            cnt = 0;
            if (rand_lat) lat = $urandom_range(1, 3);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        bit          found;
        bit          r;
        bit          rd;
        logic [31:0] ra;

        rst       = 1'b1;
        redirect  = 1'b0;
        advance   = 1'b0;
        req_addr  = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        lat       = 2;
        cnt       = 0;
        rand_lat  = 1'b0;
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_queue_count", 32'(queue_count), 32'h0);

        // fill from reset with no consumption
        issued.delete();
        repeat (12) step(0, 0, 0, 0);
        chk("fill_mem_req", 32'(mem_req), 32'h0);
        chk("fill_count", 32'(queue_count), 32'd4);
        chk("fill_inst", inst, 32'hA000);
        chk("fill_inst_pc", inst_pc, 32'h0);
        chk("fill_issued_n", 32'(issued.size()), 32'd4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("fill_issued", issued[i], 32'(4 * i));

        // drain with advance held, then redirect while the read to 0x10 is in flight
        popped.delete();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!m_out && q.size() < DEPTH && m_next == 32'h10) begin
                found = 1'b1;
                break;
            end
            step(0, 0, 0, 1);
        end
        chk("wait_req_0x10", 32'(found), 32'h1);
        k = popped.size();
        step(0, 1, 32'h103, 1);
        repeat (24) step(0, 0, 0, 1);
        for (int i = 0; i < k; i++)
            chk("seq_pc", popped[i], 32'(4 * i));
        chk("redir_pops", 32'(popped.size() > k + 1), 32'h1);
        if (popped.size() > k + 1) begin
            chk("redir_first_pc", popped[k], 32'h100);
            chk("redir_second_pc", popped[k + 1], 32'h104);
        end

        // redirect coinciding with mem_ready
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_out && !m_stale) begin
                found = 1'b1;
                break;
            end
            step(0, 0, 0, 0);
        end
        chk("wait_ready", 32'(found), 32'h1);
        step(0, 1, 32'h200, 1);
        chk("coincide_mem_req", 32'(mem_req), 32'h1);
        chk("coincide_mem_addr", mem_addr, 32'h200);
        chk("coincide_valid", 32'(inst_valid), 32'h0);

        // wrap across the top of the address space
        repeat (12) step(0, 0, 0, 0);
        issued.delete();
        step(0, 1, 32'hFFFF_FFF8, 0);
        repeat (14) step(0, 0, 0, 1);
        chk("wrap_issued_n", 32'(issued.size() >= 4), 32'h1);
        if (issued.size() >= 4) begin
            chk("wrap_0", issued[0], 32'hFFFF_FFF8);
            chk("wrap_1", issued[1], 32'hFFFF_FFFC);
            chk("wrap_2", issued[2], 32'h0000_0000);
            chk("wrap_3", issued[3], 32'h0000_0004);
        end

        // reset pulse with a read outstanding
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_out) begin
                found = 1'b1;
                break;
            end
            step(0, 0, 0, 1);
        end
        chk("wait_outstanding", 32'(found), 32'h1);
        step(1, 0, 0, 0);
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_count", 32'(queue_count), 32'h0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        popped.delete();
        issued.delete();
        repeat (20) step(0, 0, 0, 1);
        chk("postrst_issued_n", 32'(issued.size() > 0), 32'h1);
        if (issued.size() > 0) chk("postrst_first_addr", issued[0], RESET_PC);
        for (int i = 0; i < popped.size(); i++)
            chk("postrst_pc", popped[i], 32'(4 * i));

        // randomized traffic with random latency
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            rd = !r && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else ra = $urandom;
            step(r, rd, ra, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
